// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and binarization helper for the conv accumulator.
package conv_pkg;

  localparam int NUM_TAPS = 9;
  localparam int ADDR_W   = 12;
  localparam int IDX_W    = 4;
  localparam int WORD_W   = 16;

  // Word-buffer state: IDLE = empty, FILL = partial word held, WRITE = strobe cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } acc_state_e;

  // Sum of +/-1 products is numTaps - 2*negCnt; non-negative (ties included) maps to 1.
  function automatic logic binarize(input int numTaps, input int negCnt);
    return ((numTaps - 2 * negCnt) >= 0);
  endfunction

endpackage

// File: rtl/conv_accumulator_if.sv
// Window input bus and SRAM write bus of the conv accumulator.
interface conv_accumulator_if #(
  parameter int NUM_TAPS = conv_pkg::NUM_TAPS,
  parameter int ADDR_W   = conv_pkg::ADDR_W,
  parameter int IDX_W    = conv_pkg::IDX_W,
  parameter int WORD_W   = conv_pkg::WORD_W
);

  logic                go;
  logic [NUM_TAPS-1:0] negative_flags;
  logic [ADDR_W-1:0]   write_addr_in;
  logic [IDX_W-1:0]    idx_in;
  logic                last_in;

  logic                sram_write_enable;
  logic [ADDR_W-1:0]   sram_write_address;
  logic [WORD_W-1:0]   sram_write_data;
  logic                done;
  logic [ADDR_W-1:0]   words_written;

  // Window producer side: drives windows, observes writes.
  modport master (
    output go, negative_flags, write_addr_in, idx_in, last_in,
    input  sram_write_enable, sram_write_address, sram_write_data, done, words_written
  );

  // Accumulator side.
  modport slave (
    input  go, negative_flags, write_addr_in, idx_in, last_in,
    output sram_write_enable, sram_write_address, sram_write_data, done, words_written
  );

endinterface

// File: rtl/popcount_tree.sv
// Counts the set bits of an N-bit vector.
module popcount_tree #(
  parameter int N     = 9,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     bits_i,
  output logic [CNT_W-1:0] count_o
);

  // Written as a plain accumulation; synthesis rebalances it into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// Binarizes XNOR-popcount windows and packs the result bits into SRAM words.
module conv_accumulator #(
  parameter int NUM_TAPS = conv_pkg::NUM_TAPS,
  parameter int ADDR_W   = conv_pkg::ADDR_W,
  parameter int IDX_W    = conv_pkg::IDX_W,
  parameter int WORD_W   = conv_pkg::WORD_W
) (
  input logic              clock,
  input logic              reset,
  conv_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);

  logic [CNT_W-1:0] neg_cnt;

  logic             s1_valid_q;
  logic [CNT_W-1:0] s1_cnt_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_last_q;

  logic             s2_valid_q;
  logic             s2_bit_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [IDX_W-1:0] s2_idx_q;
  logic             s2_last_q;

  conv_pkg::acc_state_e state_q, state_d;
  logic [WORD_W-1:0] word_buf_q, word_buf_d;
  logic [ADDR_W-1:0] held_addr_q, held_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] count_q, count_d;

  logic              insert;
  logic              trigger;
  logic [WORD_W-1:0] merged;

  popcount_tree #(
    .N     (NUM_TAPS),
    .CNT_W (CNT_W)
  ) u_popcount (
    .bits_i  (bus.negative_flags),
    .count_o (neg_cnt)
  );

  // Stage 1: capture the negative count and window metadata on go cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_addr_q  <= '0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= bus.go;
      if (bus.go) begin
        s1_cnt_q  <= neg_cnt;
        s1_addr_q <= bus.write_addr_in;
        s1_idx_q  <= bus.idx_in;
        s1_last_q <= bus.last_in;
      end
    end
  end

  // Stage 2: binarize the count into the single result bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_bit_q   <= 1'b0;
      s2_addr_q  <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_bit_q  <= conv_pkg::binarize(NUM_TAPS, int'(s1_cnt_q));
        s2_addr_q <= s1_addr_q;
        s2_idx_q  <= s1_idx_q;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Packing: merge the new bit and decide whether this insert completes a word.
  always_comb begin
    insert  = s2_valid_q;
    trigger = s2_valid_q && ((s2_idx_q == IDX_W'(WORD_W - 1)) || s2_last_q);
    merged  = word_buf_q;
    merged[s2_idx_q] = s2_bit_q;

    word_buf_d  = word_buf_q;
    held_addr_d = held_addr_q;
    if (insert) begin
      word_buf_d  = trigger ? '0 : merged;
      held_addr_d = s2_addr_q;
    end

    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (trigger) begin
      wr_addr_d = held_addr_d;
      wr_data_d = merged;
    end
    done_d  = trigger && s2_last_q;
    count_d = count_q + ADDR_W'(trigger);
  end

  // Next state: WRITE whenever a word completes, otherwise track buffer occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      conv_pkg::IDLE: begin
        if (insert) state_d = trigger ? conv_pkg::WRITE : conv_pkg::FILL;
      end
      conv_pkg::FILL: begin
        if (trigger) state_d = conv_pkg::WRITE;
      end
      conv_pkg::WRITE: begin
        if (insert) state_d = trigger ? conv_pkg::WRITE : conv_pkg::FILL;
        else        state_d = conv_pkg::IDLE;
      end
      default: state_d = conv_pkg::IDLE;
    endcase
  end

  // State, word buffer and write-port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= conv_pkg::IDLE;
      word_buf_q  <= '0;
      held_addr_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_buf_q  <= word_buf_d;
      held_addr_q <= held_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign bus.sram_write_enable  = (state_q == conv_pkg::WRITE);
  assign bus.sram_write_address = wr_addr_q;
  assign bus.sram_write_data    = wr_data_q;
  assign bus.done               = done_q;
  assign bus.words_written      = count_q;

endmodule
